wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-port (ALU, load) writeback arbiter in front of a single
// register-file write port, with a destination scoreboard for issue hazards.
// Optional build macro: WB_RR_ARB_EN selects round-robin contention handling
// (default: load port always wins on contention).
module wb_port_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic            wb_orphan
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic            orphan_q;
    logic            alu_win;
    logic            wb_acc;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

`ifdef WB_RR_ARB_EN
    // 1 when the ALU port received the most recent grant
    logic last_alu_q;

    // Track the most recent grant; reset leaves the pointer on the load port
    always_ff @(posedge clk) begin
        if (reset)       last_alu_q <= 1'b1;
        else if (wb_acc) last_alu_q <= alu_ready;
    end

    assign alu_win = ~last_alu_q;
`else
    assign alu_win = 1'b0;
`endif

    // Grant selection; ready is purely a function of current valids and pointer
    always_comb begin
        alu_ready = ~reset & alu_valid & (~mem_valid | alu_win);
        mem_ready = ~reset & mem_valid & (~alu_valid | ~alu_win);
        wb_acc    = alu_ready | mem_ready;
        wb_rd     = alu_ready ? alu_rd   : mem_rd;
        wb_data   = alu_ready ? alu_data : mem_data;
    end

    // Hazard check on registered scoreboard only; a same-cycle clear does not bypass
    always_comb begin
        issue_stall = ~reset & issue_valid &
                      ((issue_rs1 != 5'd0 && busy_q[issue_rs1]) ||
                       (issue_rs2 != 5'd0 && busy_q[issue_rs2]) ||
                       (issue_rd  != 5'd0 && busy_q[issue_rd]));
    end

    // Scoreboard next state: clear first so a same-index set overrides it
    always_comb begin
        busy_d = busy_q;
        if (wb_acc && wb_rd != 5'd0)
            busy_d[wb_rd] = 1'b0;
        if (issue_valid && !issue_stall && issue_rd != 5'd0)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Registered write port, scoreboard and sticky orphan flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            orphan_q   <= 1'b0;
        end else begin
            rf_we_q <= wb_acc && wb_rd != 5'd0;
            if (wb_acc) begin
                rf_waddr_q <= wb_rd;
                rf_wdata_q <= wb_data;
            end
            busy_q <= busy_d;
            if (wb_acc && wb_rd != 5'd0 && !busy_q[wb_rd])
                orphan_q <= 1'b1;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy_vec  = busy_q;
    assign wb_orphan = orphan_q;

endmodule
